// File: rtl/screen_frame_feeder.sv
// screen_frame_feeder
//   CPU-bus peripheral feeding the screen64x64 matrix. Software writes a START
//   command and then streams 12-bit pixels into a small FIFO. The block replays
//   them as one init pulse followed by paced wr_data pulses with the pixel on
//   mat_in. It also reports busy/done/overflow status.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   cs       peripheral select
//   wr, rd   bus write / read strobes (qualified by cs)
//   addr     register select: 0=CTRL, 1=PIXEL, 2=STATUS
//   d_in     bus write data
//   d_out    registered bus read data, holds until the next read
//   mat_in   pixel to screen, {20'b0, pixel}
//   wr_data  1-cycle pixel strobe to screen
//   init     1-cycle frame-start strobe to screen
module screen_frame_feeder #(
    parameter int NUM_PIXELS = 4096,
    parameter int PIXEL_BITS = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic [31:0] mat_in,
    output logic        wr_data,
    output logic        init
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_PIXELS) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0]    ADDR_CTRL   = 2'd0;
    localparam logic [1:0]    ADDR_PIXEL  = 2'd1;
    localparam logic [1:0]    ADDR_STATUS = 2'd2;
    localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_COUNT  = CW'(NUM_PIXELS);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT_HI,
        INIT_LO,
        FEED_HI,
        FEED_LO
    } state_t;

    state_t                state_q, state_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [PIXEL_BITS-1:0] mat_in_q, mat_in_d;
    logic [31:0]           d_out_q, d_out_d;

    logic [PIXEL_BITS-1:0] fifo_mem [FIFO_DEPTH];

    logic [AW:0] level;
    logic [7:0]  level_byte;
    logic        empty, full;
    logic        bus_wr, bus_rd, start, pix_wr;
    logic        push, pop;
    logic [31:0] status_word;
    logic        unused_bits;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign level_byte = 8'(level);
    assign empty      = (level == '0);
    assign full       = (level == FULL_LEVEL);

    assign bus_wr = cs & wr;
    assign bus_rd = cs & rd;
    assign start  = bus_wr && (addr == ADDR_CTRL) && d_in[0];
    assign pix_wr = bus_wr && (addr == ADDR_PIXEL);

    assign status_word = {16'b0, level_byte, 5'b0, ovf_q, done_q, busy_q};

    assign unused_bits = ^d_in[31:PIXEL_BITS];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pix_cnt_d = pix_cnt_q;
        gap_d     = gap_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        mat_in_d  = mat_in_q;
        d_out_d   = d_out_q;
        pop       = 1'b0;
        push      = 1'b0;

        case (state_q)
            IDLE: ;
            INIT_HI: state_d = INIT_LO;
            INIT_LO: begin
                state_d = FEED_LO;
                gap_d   = '0;
            end
            FEED_LO: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (pix_cnt_q == LAST_COUNT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!empty) begin
                    // Loading mat_in at the pop keeps it stable across the
                    // whole high cycle and the following gap.
                    pop      = 1'b1;
                    mat_in_d = fifo_mem[rd_ptr_q[AW-1:0]];
                    state_d  = FEED_HI;
                end
            end
            FEED_HI: begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                gap_d     = GAP_RELOAD;
                state_d   = FEED_LO;
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a push into a full FIFO
        // is still accepted.
        push = pix_wr && (!full || pop);
        if (pix_wr && !push) begin
            ovf_d = 1'b1;
        end
        if (bus_wr && (addr == ADDR_STATUS) && d_in[2]) begin
            ovf_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // START wins over whatever the FSM was doing and aborts the frame.
        if (start) begin
            state_d   = INIT_HI;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pix_cnt_d = '0;
            gap_d     = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            mat_in_d  = mat_in_q;
        end

        if (bus_rd) begin
            d_out_d = (addr == ADDR_STATUS) ? status_word : 32'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pix_cnt_q <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mat_in_q  <= '0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pix_cnt_q <= pix_cnt_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            mat_in_q  <= mat_in_d;
            d_out_q   <= d_out_d;
        end
    end

    // Pixel storage carries no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= d_in[PIXEL_BITS-1:0];
        end
    end

    assign d_out   = d_out_q;
    assign mat_in  = {{(32 - PIXEL_BITS){1'b0}}, mat_in_q};
    assign wr_data = (state_q == FEED_HI);
    assign init    = (state_q == INIT_HI);

endmodule

// File: tb/tb_screen_frame_feeder.sv
module tb_screen_frame_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, wr, rd;
    logic [1:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out, mat_in;
    logic        wr_data, init;

    int errors = 0;
    int checks = 0;

    // Monitor state, written only by the monitor process.
    int          pulse_cnt = 0;
    int          init_cnt  = 0;
    logic [31:0] seen[$];
    logic        prev_wr   = 1'b0;

    screen_frame_feeder #(
        .NUM_PIXELS(8),
        .PIXEL_BITS(12),
        .FIFO_DEPTH(16),
        .GAP_CYCLES(1)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .d_in(d_in), .d_out(d_out), .mat_in(mat_in), .wr_data(wr_data), .init(init)
    );

    always #5 clk = ~clk;

    // Sample just after each rising edge: record pulses and check pulse shape.
    always @(posedge clk) begin
        #1;
        if (init) init_cnt++;
        if (wr_data) begin
            pulse_cnt++;
            seen.push_back(mat_in);
            checks++;
            if (prev_wr || init) begin
                errors++;
                $display("FAIL pulse_shape: prev_wr=%0b init=%0b, required both 0", prev_wr, init);
            end
        end
        prev_wr = wr_data;
    end

    // Bus tasks are entered at a falling edge and return at a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = 32'h0;
        $display("write addr=%0d data=%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
        $display("read  addr=%0d data=%08h", a, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        checks++;
        if (d_out !== 32'h0 || mat_in !== 32'h0 || wr_data !== 1'b0 || init !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: d_out=%08h mat_in=%08h wr_data=%b init=%b, required all 0",
                     d_out, mat_in, wr_data, init);
        end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %08h, required 00000000", s);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        int base;
        base = pulse_cnt;
        for (int i = 0; i < 17; i++) bus_write(2'd1, 32'h200 + i);
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0000_1004) begin
            errors++;
            $display("FAIL overflow_status: got %08h, required 00001004", s);
        end
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0000_1000) begin
            errors++;
            $display("FAIL ovf_clear: got %08h, required 00001000", s);
        end
        checks++;
        if (pulse_cnt != base) begin
            errors++;
            $display("FAIL idle_no_pulse: got %0d pulses, required 0", pulse_cnt - base);
        end
    endtask

    task automatic test_frame();
        logic [31:0] s;
        logic [31:0] exp_pix [3];
        int base, ibase;
        exp_pix[0] = 32'hF00; exp_pix[1] = 32'h0F0; exp_pix[2] = 32'h00F;
        base = pulse_cnt; ibase = init_cnt;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) bus_write(2'd1, exp_pix[i]);
        repeat (20) @(negedge clk);
        checks++;
        if (init_cnt - ibase != 1) begin
            errors++;
            $display("FAIL frame_init: got %0d init pulses, required 1", init_cnt - ibase);
        end
        checks++;
        if (pulse_cnt - base != 3) begin
            errors++;
            $display("FAIL frame_pulses: got %0d, required 3", pulse_cnt - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[base + i] !== exp_pix[i]) begin
                    errors++;
                    $display("FAIL frame_pixel%0d: got %08h, required %08h", i, seen[base + i], exp_pix[i]);
                end
            end
        end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h1) begin
            errors++;
            $display("FAIL frame_status: got %08h, required 00000001", s);
        end
    endtask

    // FSM is stalled in FEED_LO with an empty FIFO after test_frame.
    task automatic test_latency();
        bus_write(2'd1, 32'h123);
        checks++;
        if (wr_data !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: wr_data=%b one cycle after push, required 0", wr_data);
        end
        @(negedge clk);
        checks++;
        if (wr_data !== 1'b1 || mat_in !== 32'h123) begin
            errors++;
            $display("FAIL latency: wr_data=%b mat_in=%08h, required 1 and 00000123", wr_data, mat_in);
        end
    endtask

    task automatic test_full_frame();
        logic [31:0] s;
        int base;
        base = pulse_cnt;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 8; i++) bus_write(2'd1, 32'h300 + 32'h11 * i);
        repeat (40) @(negedge clk);
        checks++;
        if (pulse_cnt - base != 8) begin
            errors++;
            $display("FAIL full_pulses: got %0d, required 8", pulse_cnt - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (seen[base + i] !== 32'h300 + 32'h11 * i) begin
                    errors++;
                    $display("FAIL full_pixel%0d: got %08h, required %08h", i, seen[base + i], 32'h300 + 32'h11 * i);
                end
            end
        end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h2) begin
            errors++;
            $display("FAIL full_done: got %08h, required 00000002", s);
        end
        bus_write(2'd1, 32'hABC);
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_cnt - base != 8) begin
            errors++;
            $display("FAIL extra_push: got %0d pulses, required 8", pulse_cnt - base);
        end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0000_0102) begin
            errors++;
            $display("FAIL extra_status: got %08h, required 00000102", s);
        end
    endtask

    task automatic test_restart();
        logic [31:0] s;
        int base, ibase, k;
        base = pulse_cnt;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 8; i++) bus_write(2'd1, 32'h400 + i);
        k = 0;
        while (pulse_cnt - base < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pulse_cnt - base != 3) begin
            errors++;
            $display("FAIL restart_wait: got %0d pulses, required 3", pulse_cnt - base);
        end
        ibase = init_cnt;
        base = pulse_cnt;
        bus_write(2'd0, 32'h1);
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h1) begin
            errors++;
            $display("FAIL restart_status: got %08h, required 00000001", s);
        end
        for (int i = 0; i < 8; i++) bus_write(2'd1, 32'h500 + i);
        repeat (40) @(negedge clk);
        checks++;
        if (init_cnt - ibase != 1) begin
            errors++;
            $display("FAIL restart_init: got %0d init pulses, required 1", init_cnt - ibase);
        end
        checks++;
        if (pulse_cnt - base != 8) begin
            errors++;
            $display("FAIL restart_pulses: got %0d, required 8", pulse_cnt - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (seen[base + i] !== 32'h500 + i) begin
                    errors++;
                    $display("FAIL restart_pixel%0d: got %08h, required %08h", i, seen[base + i], 32'h500 + i);
                end
            end
        end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h2) begin
            errors++;
            $display("FAIL restart_done: got %08h, required 00000002", s);
        end
    endtask

    task automatic test_reset_mid_feed();
        logic [31:0] s;
        int k, base;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 8; i++) bus_write(2'd1, 32'h600 + i);
        k = 0;
        while (wr_data !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (wr_data !== 1'b1) begin
            errors++;
            $display("FAIL midreset_wait: wr_data=%b, required 1", wr_data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (wr_data !== 1'b0 || init !== 1'b0 || mat_in !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out: wr_data=%b init=%b mat_in=%08h, required 0", wr_data, init, mat_in);
        end
        base = pulse_cnt;
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0) begin
            errors++;
            $display("FAIL midreset_status: got %08h, required 00000000", s);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_cnt != base) begin
            errors++;
            $display("FAIL midreset_idle: got %0d pulses, required 0", pulse_cnt - base);
        end
    endtask

    initial begin
        cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; d_in = 32'h0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_overflow();
        test_frame();
        test_latency();
        test_full_frame();
        test_restart();
        test_reset_mid_feed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
